// File: rtl/clk_div_bank.sv
// -----------------------------------------------------------------------------
// clk_div_bank
// Multi-channel divided-clock / tick generator running from one system clock.
// Each channel owns a programmable half-period. A channel produces a 50%-duty
// divided output and a one-cycle tick in the cycle its divided output first
// reads 1. A global enable freezes all channels. A restart pulse phase-aligns
// every channel.
//
// Ports:
//   clk        system clock, all logic on the rising edge
//   reset      synchronous, active-high reset
//   en         global run enable (0 holds counters/outputs, forces tick low)
//   restart    one-cycle phase-align: clears every counter and output
//   cfg_we     half-period write strobe
//   cfg_ch     channel targeted by cfg_we (indices >= NUM_CH are ignored)
//   cfg_hp     new half-period value (0 switches the channel off)
//   div_clk    divided outputs, bit i = channel i
//   tick       one-cycle pulse on each 0->1 transition of div_clk[i]
//   ch_active  1 while channel i has a non-zero half-period
// -----------------------------------------------------------------------------
module clk_div_bank #(
    parameter int NUM_CH     = 2,
    parameter int DIV_W      = 27,
    parameter int DEFAULT_HP = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              restart,
    input  logic              cfg_we,
    input  logic [3:0]        cfg_ch,
    input  logic [DIV_W-1:0]  cfg_hp,
    output logic [NUM_CH-1:0] div_clk,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] ch_active
);

    localparam logic [DIV_W-1:0] HP_RST   = DIV_W'(DEFAULT_HP);
    localparam logic [DIV_W-1:0] CNT_ZERO = {DIV_W{1'b0}};
    localparam logic [DIV_W-1:0] CNT_ONE  = DIV_W'(1);
    localparam logic [4:0]       NUM_CH_L = 5'(NUM_CH);

    logic cfg_valid_s;

    // A write only counts when it addresses an existing channel.
    always_comb begin
        cfg_valid_s = cfg_we && ({1'b0, cfg_ch} < NUM_CH_L);
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        localparam logic [3:0] CH_IDX = 4'(i);

        logic [DIV_W-1:0] hp_r;
        logic [DIV_W-1:0] cnt_r;
        logic             div_r;
        logic             tick_r;
        logic             active_r;
        logic             sel_s;
        logic             wrap_s;

        // Channel write select and end-of-half-period detect.
        always_comb begin
            sel_s  = cfg_valid_s && (cfg_ch == CH_IDX);
            wrap_s = (cnt_r == (hp_r - CNT_ONE));
        end

        // Channel state: reset > restart > cfg write > off > hold > count.
        always_ff @(posedge clk) begin
            if (reset) begin
                hp_r     <= HP_RST;
                active_r <= (HP_RST != CNT_ZERO);
                cnt_r    <= CNT_ZERO;
                div_r    <= 1'b0;
                tick_r   <= 1'b0;
            end else if (restart) begin
                // Phase-align; a coincident write still lands in hp.
                if (sel_s) begin
                    hp_r     <= cfg_hp;
                    active_r <= (cfg_hp != CNT_ZERO);
                end else begin
                    hp_r     <= hp_r;
                    active_r <= active_r;
                end
                cnt_r  <= CNT_ZERO;
                div_r  <= 1'b0;
                tick_r <= 1'b0;
            end else if (sel_s) begin
                // New half-period always restarts the channel, so cnt < hp holds.
                hp_r     <= cfg_hp;
                active_r <= (cfg_hp != CNT_ZERO);
                cnt_r    <= CNT_ZERO;
                div_r    <= 1'b0;
                tick_r   <= 1'b0;
            end else if (hp_r == CNT_ZERO) begin
                cnt_r  <= CNT_ZERO;
                div_r  <= 1'b0;
                tick_r <= 1'b0;
            end else if (!en) begin
                cnt_r  <= cnt_r;
                div_r  <= div_r;
                tick_r <= 1'b0;
            end else if (wrap_s) begin
                cnt_r  <= CNT_ZERO;
                div_r  <= ~div_r;
                // Pulse only when the output is about to go 0->1.
                tick_r <= ~div_r;
            end else begin
                cnt_r  <= cnt_r + CNT_ONE;
                div_r  <= div_r;
                tick_r <= 1'b0;
            end
        end

        assign div_clk[i]   = div_r;
        assign tick[i]      = tick_r;
        assign ch_active[i] = active_r;
    end

endmodule

// File: tb/tb_clk_div_bank.sv
// -----------------------------------------------------------------------------
// tb_clk_div_bank
// Scoreboard bench for clk_div_bank (NUM_CH=2, DEFAULT_HP=4). The stimulus side
// tracks, per channel, the half-period and the number of enabled edges since
// the channel was last aligned. It derives the expected outputs from that in
// closed form: after k counting edges with half-period h, div_clk is
// ((k/h) odd), and tick is set when k is a multiple of h that starts a high
// phase. Each expectation is queued after its clock edge, and a monitor on the
// falling edge pops the entries and compares them.
// -----------------------------------------------------------------------------
module tb_clk_div_bank;

    localparam int NUM_CH     = 2;
    localparam int DIV_W      = 27;
    localparam int DEFAULT_HP = 4;

    logic              clk;
    logic              reset;
    logic              en;
    logic              restart;
    logic              cfg_we;
    logic [3:0]        cfg_ch;
    logic [DIV_W-1:0]  cfg_hp;
    logic [NUM_CH-1:0] div_clk;
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] ch_active;

    clk_div_bank #(
        .NUM_CH    (NUM_CH),
        .DIV_W     (DIV_W),
        .DEFAULT_HP(DEFAULT_HP)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .restart  (restart),
        .cfg_we   (cfg_we),
        .cfg_ch   (cfg_ch),
        .cfg_hp   (cfg_hp),
        .div_clk  (div_clk),
        .tick     (tick),
        .ch_active(ch_active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [NUM_CH-1:0] dc;
        logic [NUM_CH-1:0] tk;
        logic [NUM_CH-1:0] act;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   hp_m [NUM_CH];
    int   k_m  [NUM_CH];

    // Monitor: compare the DUT outputs against every queued expectation.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            n_checks += 3;
            if (div_clk !== e.dc) begin
                n_fail++;
                $display("FAIL div_clk t=%0t got %b expected %b", $time, div_clk, e.dc);
            end
            if (tick !== e.tk) begin
                n_fail++;
                $display("FAIL tick t=%0t got %b expected %b", $time, tick, e.tk);
            end
            if (ch_active !== e.act) begin
                n_fail++;
                $display("FAIL ch_active t=%0t got %b expected %b", $time, ch_active, e.act);
            end
        end
    end

    // Apply the currently driven inputs for one edge and queue the expectation.
    task automatic step();
        bit   counted [NUM_CH];
        bit   hit;
        exp_t e;
        hit = cfg_we && (int'(cfg_ch) < NUM_CH);
        for (int i = 0; i < NUM_CH; i++) counted[i] = 1'b0;
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                hp_m[i] = DEFAULT_HP;
                k_m[i]  = 0;
            end
        end else if (restart) begin
            for (int i = 0; i < NUM_CH; i++) k_m[i] = 0;
            if (hit) hp_m[cfg_ch] = int'(cfg_hp);
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (hit && int'(cfg_ch) == i) begin
                    hp_m[i] = int'(cfg_hp);
                    k_m[i]  = 0;
                end else if (hp_m[i] == 0) begin
                    k_m[i] = 0;
                end else if (en) begin
                    k_m[i]++;
                    counted[i] = 1'b1;
                end
            end
        end
        for (int i = 0; i < NUM_CH; i++) begin
            if (hp_m[i] == 0) begin
                e.dc[i]  = 1'b0;
                e.tk[i]  = 1'b0;
                e.act[i] = 1'b0;
            end else begin
                e.dc[i]  = ((k_m[i] / hp_m[i]) % 2) == 1;
                e.tk[i]  = counted[i] && (k_m[i] % hp_m[i] == 0) &&
                           ((k_m[i] / hp_m[i]) % 2 == 1);
                e.act[i] = 1'b1;
            end
        end
        @(posedge clk);
        exp_q.push_back(e);
        #1;
    endtask

    task automatic run(input int n);
        for (int c = 0; c < n; c++) step();
    endtask

    task automatic cfg(input int ch, input int hp);
        cfg_we = 1'b1;
        cfg_ch = 4'(ch);
        cfg_hp = DIV_W'(hp);
        step();
        cfg_we = 1'b0;
    endtask

    task automatic do_restart();
        restart = 1'b1;
        step();
        restart = 1'b0;
    endtask

    initial begin
        reset   = 1'b1;
        en      = 1'b1;
        restart = 1'b0;
        cfg_we  = 1'b0;
        cfg_ch  = 4'd0;
        cfg_hp  = {DIV_W{1'b0}};
        for (int i = 0; i < NUM_CH; i++) begin
            hp_m[i] = DEFAULT_HP;
            k_m[i]  = 0;
        end
        @(posedge clk);
        #1;

        // Reset state, then free-running default half-period of 4.
        run(2);
        reset = 1'b0;
        run(24);

        // Reprogram ch1 to half-period 3; ch0 keeps running.
        cfg(1, 3);
        run(20);

        // Freeze for 5 cycles in the middle of ch0's high phase (cnt=2).
        do_restart();
        run(6);
        en = 1'b0;
        run(5);
        en = 1'b1;
        run(8);

        // Channel off, then the fastest setting.
        cfg(0, 0);
        run(50);
        cfg(0, 1);
        run(8);

        // Out-of-phase channels realigned by restart.
        cfg(0, 4);
        cfg(1, 8);
        run(5);
        do_restart();
        run(34);

        // cfg write on the exact edge where ch0 would toggle.
        for (int g = 0; g < 20; g++) begin
            if (((k_m[0] + 1) % hp_m[0]) == 0) break;
            step();
        end
        cfg(0, 4);
        run(10);

        // Write to a non-existent channel is ignored.
        cfg(5, 7);
        run(10);

        // Restart coinciding with a cfg write.
        restart = 1'b1;
        cfg(1, 2);
        restart = 1'b0;
        run(10);

        // Reset on the edge where ch0 would tick.
        for (int g = 0; g < 20; g++) begin
            if (((k_m[0] + 1) % hp_m[0]) == 0 && (((k_m[0] + 1) / hp_m[0]) % 2) == 1) break;
            step();
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        run(10);

        // Drain the scoreboard with a bounded wait.
        for (int w = 0; w < 5 && exp_q.size() > 0; w++) @(negedge clk);
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain got %0d pending expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
